// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU: IDLE/SETUP/LATCH/CAPTURE/DONE sequence.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] op0_value1,
  input  logic [15:0] op0_value2,
  input  logic [15:0] op1_value1,
  input  logic [15:0] op1_value2,
  input  logic [3:0]  op0_operator,
  input  logic [3:0]  op1_operator,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        alu_latch,
  output logic [15:0] alu_value1,
  output logic [15:0] alu_value2,
  output logic [3:0]  alu_operator,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    LATCH   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant;      // 0 = requester 0 owns the in-flight operation
  logic   winner;
  logic   any_req;
  logic   latch_nxt;
  logic   ack0_nxt;
  logic   ack1_nxt;
  logic   busy_nxt;

  assign any_req = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic last_grant;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    winner = ~req0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= winner;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = LATCH;
      LATCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    latch_nxt = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    case (state_nxt)
      LATCH:   latch_nxt = 1'b1;
      DONE: begin
        ack0_nxt = ~grant;
        ack1_nxt = grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_latch <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      alu_latch <= latch_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      busy      <= busy_nxt;
    end
  end

  // Operands are frozen at the grant edge; result/flags only move on CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= 1'b0;
      alu_value1   <= 16'h0000;
      alu_value2   <= 16'h0000;
      alu_operator <= 4'h0;
      result       <= 16'h0000;
      flags        <= 4'h0;
    end else begin
      if (state == IDLE && any_req) begin
        grant        <= winner;
        alu_value1   <= winner ? op1_value1 : op0_value1;
        alu_value2   <= winner ? op1_value2 : op0_value2;
        alu_operator <= winner ? op1_operator : op0_operator;
      end
      if (state == CAPTURE) begin
        result <= alu_result;
        flags  <= alu_flags;
      end
    end
  end

endmodule
